div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative divider for MIPS DIV/DIVU in the EXE stage.
- It sits directly upstream of the HI/LO register file: remainder goes to HI and quotient to LO.
- `ready_o` drives the HI/LO write enable.
- `busy_o` tells the pipeline control to stall EXE while a division is in flight.

Parameters:
- DATA_W, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous, active-high reset; this port name is kept for codebase consistency.
- start_i  input  1  request a division; sampled only in IDLE.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- annul_i  input  1  flush/exception cancel; aborts an in-flight division.
- dividend_i  input  32  rs operand.
- divisor_i  input  32  rt operand.
- busy_o  output  1  high while state is CALC.
- ready_o  output  1  one-cycle pulse; hi_o/lo_o are valid this cycle. Connects to HI/LO we.
- hi_o  output  32  remainder.
- lo_o  output  32  quotient.

Behaviour:
- Reset (rstn=1 at a clock edge):
  - state goes to IDLE; counter, working registers, hi_o, lo_o are set to 0; ready_o=0, busy_o=0.
  - Reset overrides everything, including mid-CALC; no ready pulse follows.
- States: IDLE, CALC, DONE. Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - start_i=1, annul_i=0, divisor≠0: capture magnitudes of both operands, where magnitude = two's-complement abs if signed_i, else raw.
  - Also capture sign_q = signed_i & (dividend[31]^divisor[31]) and sign_r = signed_i & dividend[31].
  - Clear the 33-bit partial remainder and the counter, then go to CALC.
  - start_i=1, annul_i=0, divisor=0: go straight to DONE with hi_o=dividend_i and lo_o=32'hFFFFFFFF. This is a defined value for an architecturally undefined case.
  - start_i=1 with annul_i=1: stay in IDLE.
- CALC, one restoring step per cycle:
  - shift {rem, quo} left by 1, bringing the next dividend MSB into rem.
  - trial = rem − |divisor| over 33 bits. If non-negative, rem=trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - Counter increments; after the 32nd step, go to DONE.
  - On entering DONE: lo_o = sign_q ? −quo : quo, and hi_o = sign_r ? −rem : rem, both truncated to 32 bits.
  - annul_i=1 in CALC: go to IDLE at the next edge; hi_o/lo_o are unchanged and no ready pulse is issued.
- DONE:
  - ready_o=1 for exactly this one cycle; always return to IDLE at the next edge.
  - annul_i here is ignored, because the HI/LO write gating is owned by the pipeline.
- Latency: start accepted at edge k. busy_o=1 from edge k through edge k+32, and ready_o=1 in the cycle after edge k+32, i.e. 33 cycles after acceptance. Divide-by-zero: ready_o is high in the cycle after edge k.
- start_i in CALC or DONE is ignored; no queueing. A new start is accepted one cycle after DONE.
- hi_o/lo_o hold their last completed result until the next DONE.
- Signed overflow 0x80000000 / −1: the natural wrap result lo=0x80000000, hi=0; no exception is raised.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit internally.

Test Plan:
- DIVU 100/7: start at edge k → busy high for 32 cycles; ready_o single-cycle in the cycle after edge k+32; lo=14, hi=2.
- DIV −7/2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/−2 → lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- Divisor=0: DIVU 0x1234/0 → busy never high; ready the cycle after start; hi=0x1234, lo=0xFFFFFFFF.
- Complete 100/7, then start 50/3 and assert annul_i at iteration 10 → returns to IDLE, no ready; hi/lo remain 2/14. A following 50/3 completes as lo=16, hi=2.
- Assert rstn during CALC → next cycle state IDLE, busy_o=0, hi_o=lo_o=0, no ready pulse. start_i held high during CALC → no second division launched.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS DIV/DIVU, remainder to HI and quotient to LO
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              annul_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem, quo, dvs, a_mag, b_mag, rem_nx, quo_nx;
    logic [DATA_W:0]   shifted, trial;
    logic              sign_q, sign_r;
    always_comb begin
        a_mag   = (signed_i & dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
        b_mag   = (signed_i & divisor_i[DATA_W-1]) ? -divisor_i : divisor_i;
        shifted = {rem, quo[DATA_W-1]};
        trial   = shifted - {1'b0, dvs};
        rem_nx  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_nx  = {quo[DATA_W-2:0], ~trial[DATA_W]};
    end
    // rem never exceeds 32 bits since it stays below the divisor; the 33rd bit lives only in shifted/trial
    always_ff @(posedge clk) begin
        if (rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            case (state)
                IDLE: if (start_i && !annul_i) begin
                    if (divisor_i == '0) begin
                        hi_o  <= dividend_i;
                        lo_o  <= '1;
                        state <= DONE;
                    end else begin
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        sign_q <= signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                        sign_r <= signed_i & dividend_i[DATA_W-1];
                        rem    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: if (annul_i) begin
                    state <= IDLE;
                end else begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        lo_o  <= sign_q ? -quo_nx : quo_nx;
                        hi_o  <= sign_r ? -rem_nx : rem_nx;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy_o  = (state == CALC);
    assign ready_o = (state == DONE);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with a result scoreboard popped by a ready-driven monitor
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        busy_o, ready_o;
    logic [31:0] hi_o, lo_o;
    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    div_unit dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o), .ready_o(ready_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hi", hi_o, e[63:32]);
                chk("lo", lo_o, e[31:0]);
            end
        end
    end

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit hold);
        int lat, nbusy;
        @(negedge clk);
        start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
        exp_q.push_back({ehi, elo});
        @(posedge clk);
        #1 if (!hold) start_i = 1'b0;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (busy_o) nbusy++;
            if (ready_o) begin
                lat = i;
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        chk("latency", lat, (b == 0) ? 32'd1 : 32'd33);
        chk("busy_cycles", nbusy, (b == 0) ? 32'd0 : 32'd32);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_ready", {31'd0, ready_o}, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        rstn = 1'b0;
        run(0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run(1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0);
        run(1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);
        run(0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 0);
        run(0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 0);
        run(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 0);
        run(0, 32'd5, 32'd9, 32'd5, 32'd0, 0);
        run(0, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 0);
        run(1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0);
        run(0, 32'd100, 32'd7, 32'd2, 32'd14, 1);
        @(negedge clk);
        chk("held_start_no_relaunch", {31'd0, busy_o}, 0);
        // annul a 50/3 mid-flight; HI/LO must keep 2/14 and no ready may appear
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd3;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1 annul_i = 1'b0;
        chk("annul_busy", {31'd0, busy_o}, 0);
        repeat (40) @(negedge clk);
        chk("annul_hi", hi_o, 32'd2);
        chk("annul_lo", lo_o, 32'd14);
        run(0, 32'd50, 32'd3, 32'd2, 32'd16, 0);
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy", {31'd0, busy_o}, 0);
        chk("midreset_ready", {31'd0, ready_o}, 0);
        chk("midreset_hi", hi_o, 0);
        chk("midreset_lo", lo_o, 0);
        rstn = 1'b0;
        repeat (40) @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
